// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main control FSM: sequences PC/IR/regfile/memory/ALU muxes per state.
// Optional: define MC_CTRL_ADDI_EN to add the ADDIEX/ADDIWB path for addi.
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`endif
        S_JEX     = 4'd11
    } state_t;

    state_t state_q, state_d;

    logic       pcwrite_c, branch_c;
    logic       irwrite_c, memwrite_c, regwrite_c;
    logic [2:0] funct_alu;
    logic       funct_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = S_FETCH;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b010;
        pcsrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_c = 1'b1;
                pcwrite_c = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                instr_done = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                // Unknown funct aborts here without ever reaching writeback
                if (funct_ok) begin
                    alucontrol = funct_alu;
                    state_d    = S_RTYPEWB;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch_c   = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                instr_done = 1'b1;
            end
`endif
            S_JEX: begin
                pcsrc      = 2'b10;
                pcwrite_c  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural write enables are held off for as long as reset is high
    assign pcen     = (pcwrite_c | (branch_c & zero)) & ~reset;
    assign irwrite  = irwrite_c  & ~reset;
    assign memwrite = memwrite_c & ~reset;
    assign regwrite = regwrite_c & ~reset;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed testbench for mips_multicycle_controller.
// Build with +define+MC_CTRL_ADDI_EN to check the addi path instead of its abort.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       instr_done, illegal_op;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .pcsrc(pcsrc), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        step(); step();
        total_cnt++; if (pcen !== 1'b0) $display("FAIL rst_pcen got %b want 0", pcen); else pass_cnt++;
        total_cnt++; if (irwrite !== 1'b0) $display("FAIL rst_irwrite got %b want 0", irwrite); else pass_cnt++;
        total_cnt++; if (alusrcb !== 2'b01) $display("FAIL rst_alusrcb got %b want 01", alusrcb); else pass_cnt++;
        total_cnt++; if (alucontrol !== 3'b010) $display("FAIL rst_aluctl got %b want 010", alucontrol); else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++; if (irwrite !== 1'b1) $display("FAIL rst_rel_irwrite got %b want 1", irwrite); else pass_cnt++;
        total_cnt++; if (pcen !== 1'b1) $display("FAIL rst_rel_pcen got %b want 1", pcen); else pass_cnt++;
    endtask

    task automatic test_lw();
        op = 6'b100011; zero = 1'b1;
        total_cnt++; if (irwrite !== 1'b1) $display("FAIL lw_c0_irwrite got %b want 1", irwrite); else pass_cnt++;
        step();
        total_cnt++; if (alusrcb !== 2'b11) $display("FAIL lw_c1_alusrcb got %b want 11", alusrcb); else pass_cnt++;
        total_cnt++; if (illegal_op !== 1'b0) $display("FAIL lw_c1_illegal got %b want 0", illegal_op); else pass_cnt++;
        step();
        total_cnt++; if ({alusrca, alusrcb} !== 3'b110) $display("FAIL lw_c2_src got %b want 110", {alusrca, alusrcb}); else pass_cnt++;
        total_cnt++; if (pcen !== 1'b0) $display("FAIL lw_c2_pcen got %b want 0", pcen); else pass_cnt++;
        step();
        total_cnt++; if ({iord, regwrite} !== 2'b10) $display("FAIL lw_c3_iord_rw got %b want 10", {iord, regwrite}); else pass_cnt++;
        step();
        total_cnt++; if ({regwrite, memtoreg, instr_done} !== 3'b111) $display("FAIL lw_c4_wb got %b want 111", {regwrite, memtoreg, instr_done}); else pass_cnt++;
        step();
        total_cnt++; if ({irwrite, instr_done} !== 2'b10) $display("FAIL lw_c5_fetch got %b want 10", {irwrite, instr_done}); else pass_cnt++;
        zero = 1'b0;
    endtask

    task automatic test_sw();
        bit saw_rw = 1'b0;
        op = 6'b101011;
        if (regwrite) saw_rw = 1'b1;
        step();
        if (regwrite) saw_rw = 1'b1;
        step();
        if (regwrite) saw_rw = 1'b1;
        total_cnt++; if (memwrite !== 1'b0) $display("FAIL sw_c2_memwrite got %b want 0", memwrite); else pass_cnt++;
        step();
        if (regwrite) saw_rw = 1'b1;
        total_cnt++; if ({memwrite, iord, instr_done} !== 3'b111) $display("FAIL sw_c3 got %b want 111", {memwrite, iord, instr_done}); else pass_cnt++;
        step();
        total_cnt++; if ({irwrite, memwrite} !== 2'b10) $display("FAIL sw_c4_fetch got %b want 10", {irwrite, memwrite}); else pass_cnt++;
        total_cnt++; if (saw_rw !== 1'b0) $display("FAIL sw_no_regwrite got %b want 0", saw_rw); else pass_cnt++;
    endtask

    task automatic test_rtype();
        logic [5:0] f_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] a_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            op = 6'b000000; funct = f_tab[i];
            step(); step();
            total_cnt++; if (alucontrol !== a_tab[i]) $display("FAIL r%0d_aluctl got %b want %b", i, alucontrol, a_tab[i]); else pass_cnt++;
            total_cnt++; if ({alusrca, alusrcb, regwrite} !== 4'b1000) $display("FAIL r%0d_ex got %b want 1000", i, {alusrca, alusrcb, regwrite}); else pass_cnt++;
            step();
            total_cnt++; if ({regwrite, regdst, instr_done} !== 3'b111) $display("FAIL r%0d_wb got %b want 111", i, {regwrite, regdst, instr_done}); else pass_cnt++;
            step();
            total_cnt++; if (irwrite !== 1'b1) $display("FAIL r%0d_fetch got %b want 1", i, irwrite); else pass_cnt++;
        end
    endtask

    task automatic test_rtype_illegal();
        op = 6'b000000; funct = 6'b000111;
        step(); step();
        total_cnt++; if ({illegal_op, alucontrol} !== 4'b1010) $display("FAIL rill_c2 got %b want 1010", {illegal_op, alucontrol}); else pass_cnt++;
        total_cnt++; if (instr_done !== 1'b0) $display("FAIL rill_c2_done got %b want 0", instr_done); else pass_cnt++;
        step();
        total_cnt++; if ({irwrite, regwrite} !== 2'b10) $display("FAIL rill_c3 got %b want 10", {irwrite, regwrite}); else pass_cnt++;
        funct = 6'b0;
    endtask

    task automatic test_beq(input logic z);
        op = 6'b000100; zero = z;
        step(); step();
        total_cnt++; if (pcen !== z) $display("FAIL beq%0d_pcen got %b want %b", z, pcen, z); else pass_cnt++;
        total_cnt++; if ({pcsrc, alucontrol, instr_done} !== 6'b011101) $display("FAIL beq%0d_ctl got %b want 011101", z, {pcsrc, alucontrol, instr_done}); else pass_cnt++;
        step();
        total_cnt++; if (irwrite !== 1'b1) $display("FAIL beq%0d_fetch got %b want 1", z, irwrite); else pass_cnt++;
        zero = 1'b0;
    endtask

    task automatic test_j();
        op = 6'b000010;
        step(); step();
        total_cnt++; if ({pcen, pcsrc, instr_done} !== 4'b1101) $display("FAIL j_c2 got %b want 1101", {pcen, pcsrc, instr_done}); else pass_cnt++;
        step();
        total_cnt++; if (irwrite !== 1'b1) $display("FAIL j_fetch got %b want 1", irwrite); else pass_cnt++;
    endtask

    task automatic test_addi();
        op = 6'b001000;
`ifdef MC_CTRL_ADDI_EN
        step();
        total_cnt++; if (illegal_op !== 1'b0) $display("FAIL addi_c1_illegal got %b want 0", illegal_op); else pass_cnt++;
        step();
        total_cnt++; if ({alusrca, alusrcb} !== 3'b110) $display("FAIL addi_c2 got %b want 110", {alusrca, alusrcb}); else pass_cnt++;
        step();
        total_cnt++; if ({regwrite, regdst, memtoreg, instr_done} !== 4'b1001) $display("FAIL addi_c3 got %b want 1001", {regwrite, regdst, memtoreg, instr_done}); else pass_cnt++;
        step();
        total_cnt++; if (irwrite !== 1'b1) $display("FAIL addi_fetch got %b want 1", irwrite); else pass_cnt++;
`else
        step();
        total_cnt++; if (illegal_op !== 1'b1) $display("FAIL addi_c1_illegal got %b want 1", illegal_op); else pass_cnt++;
        step();
        total_cnt++; if ({irwrite, regwrite} !== 2'b10) $display("FAIL addi_c2_fetch got %b want 10", {irwrite, regwrite}); else pass_cnt++;
`endif
    endtask

    task automatic test_illegal_op();
        op = 6'b111111;
        step();
        total_cnt++; if (illegal_op !== 1'b1) $display("FAIL badop_c1 got %b want 1", illegal_op); else pass_cnt++;
        step();
        total_cnt++; if ({irwrite, illegal_op} !== 2'b10) $display("FAIL badop_c2 got %b want 10", {irwrite, illegal_op}); else pass_cnt++;
    endtask

    task automatic test_reset_midinstr();
        op = 6'b100011;
        step(); step(); step();
        total_cnt++; if (iord !== 1'b1) $display("FAIL mid_memrd_iord got %b want 1", iord); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if ({iord, alusrcb} !== 3'b001) $display("FAIL mid_fetch got %b want 001", {iord, alusrcb}); else pass_cnt++;
        total_cnt++; if ({pcen, irwrite, memwrite, regwrite} !== 4'b0000) $display("FAIL mid_en got %b want 0000", {pcen, irwrite, memwrite, regwrite}); else pass_cnt++;
        step();
        total_cnt++; if ({regwrite, memtoreg, irwrite} !== 3'b000) $display("FAIL mid_hold got %b want 000", {regwrite, memtoreg, irwrite}); else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        test_lw();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_rtype_illegal();
        test_beq(1'b1);
        test_beq(1'b0);
        test_j();
        test_addi();
        test_illegal_op();
        test_reset_midinstr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
